// File: rtl/npc_core_mc.sv
// Multi-cycle RV32I/E core (ADDI, ADD, LUI, AUIPC, JAL, JALR, EBREAK) with a stallable fetch port.
// Optional macro COMMIT_TRACE_EN adds the commit_valid/commit_pc/commit_inst retire trace outputs.
module npc_core_mc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NR_REGS  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [31:0]            imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic [31:0]            pc,
  output logic                   halt,
  output logic [1:0]             halt_code,
  output logic [31:0]            exit_value,
  output logic [NR_REGS*32-1:0]  rf_dbg
`ifdef COMMIT_TRACE_EN
  ,
  output logic                   commit_valid,
  output logic [31:0]            commit_pc,
  output logic [31:0]            commit_inst
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

  state_t                    state, state_nx;
  logic [NR_REGS-1:0][31:0]  regs;
  logic [31:0]               inst;

  logic [6:0]         opcode;
  logic [4:0]         rd, rs1, rs2;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [31:0] imm_i, imm_j;
  logic [31:0]        imm_u;
  logic [31:0]        rs1_val, rs2_val, wdata, pc_next;
  logic               legal, is_ebreak, wr_en;
  logic               use_rd, use_rs1, use_rs2;

  function automatic logic reg_ok(input logic [4:0] idx);
    return 32'(idx) < NR_REGS;
  endfunction

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Out-of-range indices read as zero; they are trapped as illegal anyway
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    for (int i = 1; i < NR_REGS; i++) begin
      if (rs1 == 5'(i)) rs1_val = regs[i];
      if (rs2 == 5'(i)) rs2_val = regs[i];
    end
  end

  always_comb begin
    legal     = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    wdata     = '0;
    pc_next   = pc + 32'd4;
    is_ebreak = (inst & 32'hfff0_707f) == 32'h0010_0073;
    case (opcode)
      7'b0010011: if (funct3 == 3'b000) begin
        legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
        wdata = rs1_val + imm_i;
      end
      7'b0110011: if (funct3 == 3'b000 && funct7 == 7'b0) begin
        legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        wdata = rs1_val + rs2_val;
      end
      7'b0110111: begin
        legal = 1'b1; use_rd = 1'b1;
        wdata = imm_u;
      end
      7'b0010111: begin
        legal = 1'b1; use_rd = 1'b1;
        wdata = pc + imm_u;
      end
      7'b1101111: begin
        legal = 1'b1; use_rd = 1'b1;
        wdata   = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      7'b1100111: if (funct3 == 3'b000) begin
        legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
        wdata   = pc + 32'd4;
        pc_next = (rs1_val + imm_i) & ~32'd1;
      end
      default: ;
    endcase
    if ((use_rd && !reg_ok(rd)) || (use_rs1 && !reg_ok(rs1)) || (use_rs2 && !reg_ok(rs2)))
      legal = 1'b0;
    wr_en = legal && (rd != 5'd0);
  end

  always_comb begin
    state_nx       = state;
    imem_req_valid = 1'b0;
    halt           = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nx = S_WAIT;
      end
      S_WAIT:  if (imem_rsp_valid) state_nx = S_EXEC;
      S_EXEC:  state_nx = (is_ebreak || !legal) ? S_HALT : S_FETCH;
      S_HALT:  halt = 1'b1;
      default: state_nx = S_FETCH;
    endcase
  end

  assign imem_addr = pc;
  assign rf_dbg    = regs;

  always_ff @(posedge clk) begin
    if (state == S_WAIT && imem_rsp_valid) inst <= imem_rsp_data;
  end

  // A halting instruction leaves pc and the register file untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      halt_code  <= 2'b00;
      exit_value <= '0;
      regs       <= '0;
    end else begin
      state <= state_nx;
      if (state == S_EXEC) begin
        if (is_ebreak) begin
          halt_code  <= 2'b01;
          exit_value <= regs[10];
        end else if (!legal) begin
          halt_code  <= 2'b10;
          exit_value <= regs[10];
        end else begin
          pc <= pc_next;
          for (int i = 1; i < NR_REGS; i++)
            if (wr_en && rd == 5'(i)) regs[i] <= wdata;
        end
      end
    end
  end

`ifdef COMMIT_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
    end else begin
      commit_valid <= 1'b0;
      if (state == S_EXEC && legal && !is_ebreak) begin
        commit_valid <= 1'b1;
        commit_pc    <= pc;
        commit_inst  <= inst;
      end
    end
  end
`endif

endmodule

// File: tb/tb_npc_core_mc.sv
// Directed bench for npc_core_mc: an RV32I core and an RV32E core run the same programs in lockstep.
module tb_npc_core_mc;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;

  logic req_valid, e_req_valid, halt, e_halt;
  logic [31:0] addr, e_addr, pc, e_pc, exitv, e_exitv;
  logic [1:0] hcode, e_hcode;
  logic [1023:0] rf;
  logic [511:0] e_rf;
`ifdef COMMIT_TRACE_EN
  logic cv, e_cv;
  logic [31:0] cpc, cinst, e_cpc, e_cinst;
`endif

  logic [31:0] mem [64];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  npc_core_mc #(.RESET_PC(RPC), .NR_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .pc(pc), .halt(halt), .halt_code(hcode), .exit_value(exitv), .rf_dbg(rf)
`ifdef COMMIT_TRACE_EN
    , .commit_valid(cv), .commit_pc(cpc), .commit_inst(cinst)
`endif
  );

  npc_core_mc #(.RESET_PC(RPC), .NR_REGS(16)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(e_req_valid), .imem_req_ready(req_ready), .imem_addr(e_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .pc(e_pc), .halt(e_halt), .halt_code(e_hcode), .exit_value(e_exitv), .rf_dbg(e_rf)
`ifdef COMMIT_TRACE_EN
    , .commit_valid(e_cv), .commit_pc(e_cpc), .commit_inst(e_cinst)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xr(input int i);
    return rf[i*32 +: 32];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hffff_ffff;
  endtask

  // Reset asserted for 3 cycles; returns on the negedge where rst_n is released
  task automatic do_reset();
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Serve one fetch; garbage responses are driven while the request is held off
  task automatic serve(input int rdy_dly, input int rsp_dly);
    int guard;
    logic [31:0] a;
    logic stable;
    guard = 0;
    while (req_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("serve_req_valid", 32'(req_valid), 32'd1);
    a = addr;
    stable = 1'b1;
    for (int i = 0; i < rdy_dly; i++) begin
      rsp_valid = 1'b1;
      rsp_data  = 32'hffff_ffff;
      @(negedge clk);
      if (req_valid !== 1'b1 || addr !== a) stable = 1'b0;
    end
    if (rdy_dly > 0) chk("addr_stable", 32'(stable), 32'd1);
    rsp_valid = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("wait_req_low", 32'(req_valid), 32'd0);
    for (int i = 0; i < rsp_dly; i++) @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data  = mem[a[7:2]];
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    logic any_req;

    // Reset and ADDI/ADD with zero-wait imem
    clear_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8133;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RPC);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_rf_zero", 32'(rf !== '0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_valid", 32'(req_valid), 32'd1);
    chk("rel_addr", addr, RPC);
    chk("rel_hcode", 32'(hcode), 32'd0);
    chk("rel_exit", exitv, 32'd0);
    c0 = cyc;
    serve(0, 0);
    serve(0, 0);
    @(negedge clk);
    chk("add_x1", xr(1), 32'd5);
    chk("add_x2", xr(2), 32'd10);
    chk("add_pc", pc, 32'h8000_0008);
    chk("add_cycles", 32'(cyc - c0), 32'd6);

    // JAL / JALR
    clear_mem();
    mem[0] = 32'h0080_00ef;
    mem[2] = 32'h0000_8067;
    do_reset();
    serve(0, 0);
    @(negedge clk);
    chk("jal_x1", xr(1), 32'h8000_0004);
    chk("jal_addr", addr, 32'h8000_0008);
    serve(0, 0);
    @(negedge clk);
    chk("jalr_pc", pc, 32'h8000_0004);
    chk("jalr_x0", xr(0), 32'd0);

    // EBREAK with exit value
    clear_mem();
    mem[0] = 32'h02a0_0513;
    mem[1] = 32'h0010_0073;
    do_reset();
    serve(0, 0);
    serve(0, 0);
    @(negedge clk);
    chk("ebrk_halt", 32'(halt), 32'd1);
    chk("ebrk_code", 32'(hcode), 32'd1);
    chk("ebrk_exit", exitv, 32'd42);
    chk("ebrk_pc", pc, 32'h8000_0004);
    chk("ebrk_x10", xr(10), 32'd42);
    any_req = 1'b0;
    req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid !== 1'b0) any_req = 1'b1;
    end
    req_ready = 1'b0;
    chk("ebrk_req_quiet", 32'(any_req), 32'd0);
    chk("ebrk_still_halt", 32'(halt), 32'd1);

    // Illegal word after a legal write
    clear_mem();
    mem[0] = 32'h0050_0093;
    do_reset();
    serve(0, 0);
    serve(0, 0);
    @(negedge clk);
    chk("ill_code", 32'(hcode), 32'd2);
    chk("ill_halt", 32'(halt), 32'd1);
    chk("ill_pc", pc, 32'h8000_0004);
    chk("ill_x1", xr(1), 32'd5);
    chk("ill_rf_rest", 32'(rf[1023:64] !== '0 || rf[31:0] !== '0), 32'd0);

    // RV32E: x15 legal, x16 illegal; RV32I core keeps running
    clear_mem();
    mem[0] = 32'h00f0_0793;
    mem[1] = 32'h0010_0813;
    mem[2] = 32'h0010_0073;
    do_reset();
    serve(0, 0);
    serve(0, 0);
    @(negedge clk);
    chk("e_x15", e_rf[15*32 +: 32], 32'd15);
    chk("e_code", 32'(e_hcode), 32'd2);
    chk("e_halt", 32'(e_halt), 32'd1);
    chk("e_pc", e_pc, 32'h8000_0004);
    chk("i_x16", xr(16), 32'd1);
    chk("i_running", 32'(halt), 32'd0);
    serve(0, 0);
    @(negedge clk);
    chk("i_ebrk_code", 32'(hcode), 32'd1);

    // LUI, AUIPC, negative immediate, pc wrap
    clear_mem();
    mem[0]  = 32'h1234_52b7;
    mem[1]  = 32'h0000_1317;
    mem[2]  = 32'hfff0_0393;
    mem[3]  = 32'hffc0_0067;
    mem[63] = 32'h0010_0413;
    do_reset();
    repeat (4) serve(0, 0);
    @(negedge clk);
    chk("lui_x5", xr(5), 32'h1234_5000);
    chk("auipc_x6", xr(6), 32'h8000_1004);
    chk("addi_neg_x7", xr(7), 32'hffff_ffff);
    chk("jalr_neg_addr", addr, 32'hffff_fffc);
    serve(0, 0);
    @(negedge clk);
    chk("wrap_x8", xr(8), 32'd1);
    chk("wrap_pc", pc, 32'd0);

    // Stalled imem, then reset during WAIT
    clear_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8133;
    do_reset();
    serve(5, 3);
    serve(5, 3);
    @(negedge clk);
    chk("slow_x1", xr(1), 32'd5);
    chk("slow_x2", xr(2), 32'd10);
    chk("slow_pc", pc, 32'h8000_0008);
    do_reset();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'hffff_ffff;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("rstw_pc", pc, RPC);
    chk("rstw_req", 32'(req_valid), 32'd1);
    chk("rstw_halt", 32'(halt), 32'd0);
    chk("rstw_x1", xr(1), 32'd0);
    serve(0, 0);
    @(negedge clk);
    chk("rstw_restart_x1", xr(1), 32'd5);
    chk("rstw_restart_pc", pc, 32'h8000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
